// File: rtl/phv_assemble_if.sv
// Handshake bundle between the PHV issuer, the ALU lanes and the downstream stage.
// master drives PHVs, ALU results and downstream ready; slave is phv_assemble.
interface phv_assemble_if #(
    parameter int DATA_WIDTH = 48,
    parameter int NUM_ALU    = 8,
    parameter int META_WIDTH = 256,
    parameter int PHV_LEN    = NUM_ALU*DATA_WIDTH+META_WIDTH
);
    logic [PHV_LEN-1:0]            phv_in;
    logic                          phv_in_valid;
    logic                          phv_in_ready;
    logic [NUM_ALU*DATA_WIDTH-1:0] alu_container_in;
    logic [NUM_ALU-1:0]            alu_valid_in;
    logic [PHV_LEN-1:0]            phv_out;
    logic                          phv_out_valid;
    logic                          phv_out_ready;
    logic                          err_timeout;

    modport master (
        output phv_in, phv_in_valid, alu_container_in, alu_valid_in, phv_out_ready,
        input  phv_in_ready, phv_out, phv_out_valid, err_timeout
    );

    modport slave (
        input  phv_in, phv_in_valid, alu_container_in, alu_valid_in, phv_out_ready,
        output phv_in_ready, phv_out, phv_out_valid, err_timeout
    );
endinterface

// File: rtl/phv_assemble.sv
// Merges per-lane ALU results back into the buffered PHV and holds it for downstream.
// Define PHV_ASSEMBLE_TIMEOUT_EN to enable the ALU wait timeout and err_timeout pulse.
//
// state    | meaning
// IDLE     | ready for a new PHV
// WAIT_ALU | PHV buffered, waiting for any ALU lane valid (or timeout)
// HOLD     | merged PHV presented until downstream accepts
module phv_assemble #(
    parameter int STAGE_ID   = 0,
    parameter int DATA_WIDTH = 48,
    parameter int NUM_ALU    = 8,
    parameter int META_WIDTH = 256,
    parameter int PHV_LEN    = NUM_ALU*DATA_WIDTH+META_WIDTH,
    parameter int TIMEOUT    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    phv_assemble_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_ALU, HOLD} state_t;

    state_t               state_q, state_d;
    logic [PHV_LEN-1:0]   phv_buf;
    logic [PHV_LEN-1:0]   merged;
    logic                 any_valid;
    logic                 timeout_hit;
    logic                 buf_load;
    logic                 out_load;
    logic                 out_clear;
    logic                 unused_cfg;

    // STAGE_ID is informational only; TIMEOUT is unused when the timeout is compiled out
    assign unused_cfg = ^{STAGE_ID, TIMEOUT};

    assign any_valid        = |bus.alu_valid_in;
    assign bus.phv_in_ready = (state_q == IDLE);

`ifdef PHV_ASSEMBLE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT+1);
    logic [CNT_W-1:0] wait_cnt;

    // fires on the idle cycle that brings the count to TIMEOUT; a lane valid wins
    assign timeout_hit = (state_q == WAIT_ALU) && !any_valid &&
                         (wait_cnt == CNT_W'(TIMEOUT-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state_q == IDLE)
            wait_cnt <= '0;
        else if (state_q == WAIT_ALU && !any_valid)
            wait_cnt <= wait_cnt + CNT_W'(1);
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        merged = phv_buf;
        for (int i = 0; i < NUM_ALU; i++) begin
            if (bus.alu_valid_in[i])
                merged[i*DATA_WIDTH +: DATA_WIDTH] = bus.alu_container_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.phv_in_valid)         state_d = WAIT_ALU;
            WAIT_ALU: if (any_valid || timeout_hit) state_d = HOLD;
            HOLD:     if (bus.phv_out_ready)        state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_load  = (state_q == IDLE) && bus.phv_in_valid;
        out_load  = (state_q == WAIT_ALU) && (any_valid || timeout_hit);
        out_clear = (state_q == HOLD) && bus.phv_out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_buf           <= '0;
            bus.phv_out       <= '0;
            bus.phv_out_valid <= 1'b0;
            bus.err_timeout   <= 1'b0;
        end else begin
            if (buf_load)
                phv_buf <= bus.phv_in;
            if (out_load) begin
                bus.phv_out       <= merged;
                bus.phv_out_valid <= 1'b1;
            end else if (out_clear) begin
                bus.phv_out_valid <= 1'b0;
            end
            bus.err_timeout <= timeout_hit;
        end
    end
endmodule
